// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
// Shared definitions for the push-button gesture classifier:
//   - state_t      : classifier FSM encoding (3-bit)
//   - DEF_*        : default timing constants and counter width
//   - max3()       : helper used to size the counter ceiling
// No ports (package).
// -----------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRESS1   = 3'd1,
    WAIT_GAP = 3'd2,
    PRESS2   = 3'd3,
    HELD     = 3'd4
  } state_t;

  localparam int DEF_LONG_CYCLES   = 100;
  localparam int DEF_GAP_CYCLES    = 50;
  localparam int DEF_REPEAT_CYCLES = 25;
  localparam int DEF_CNT_W         = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pb_edge_detect.sv
// -----------------------------------------------------------------------------
// pb_edge_detect
// Registers a synchronous button level and reports its rising/falling edges.
// The history register resets to 1 so a button already held at reset release
// produces no rise until it has been released and pressed again.
// Ports:
//   clk   in  : system clock
//   rst_n in  : asynchronous active-low reset
//   pb    in  : button level, synchronous to clk
//   rise  out : pb high now, low on the previous clock (combinational)
//   fall  out : pb low now, high on the previous clock (combinational)
// -----------------------------------------------------------------------------
module pb_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic pb,
  output logic rise,
  output logic fall
);

  logic pb_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pb_prev <= 1'b1;
    end else begin
      pb_prev <= pb;
    end
  end

  assign rise = pb & ~pb_prev;
  assign fall = ~pb & pb_prev;

endmodule

// File: rtl/button_press_classifier.sv
// -----------------------------------------------------------------------------
// button_press_classifier
// Classifies debounced button gestures into single-click, double-click and
// long-press, emitting one registered single-cycle pulse per gesture.
// Optional feature macro: BUTTON_AUTO_REPEAT_EN -- when defined, long_pulse
// repeats every REPEAT_CYCLES cycles while the button stays held after a long
// press. When undefined the held state is silent.
// Ports:
//   clk          in  : system clock (rising edge)
//   rst_n        in  : asynchronous active-low reset
//   pb_deb       in  : debounced button level, synchronous to clk
//   single_pulse out : one-cycle pulse, single click classified
//   double_pulse out : one-cycle pulse, double click classified
//   long_pulse   out : one-cycle pulse, long press (and auto-repeats)
//   busy         out : high whenever a gesture is in progress
// -----------------------------------------------------------------------------
module button_press_classifier
  import button_pkg::*;
#(
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int GAP_CYCLES    = DEF_GAP_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int CNT_W         = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pb_deb,
  output logic single_pulse,
  output logic double_pulse,
  output logic long_pulse,
  output logic busy
);

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  // Largest value any compare ever needs; the counter saturates here so it
  // can never wrap even if a compare were somehow skipped.
  localparam logic [CNT_W-1:0] CNT_CEIL  =
    CNT_W'(max3(LONG_CYCLES, GAP_CYCLES, REPEAT_CYCLES));

  logic rise;
  logic fall;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic             single_reg, single_next;
  logic             double_reg, double_next;
  logic             long_reg, long_next;
  logic             busy_reg, busy_next;

  pb_edge_detect u_edge (
    .clk  (clk),
    .rst_n(rst_n),
    .pb   (pb_deb),
    .rise (rise),
    .fall (fall)
  );

  assign cnt_inc = (cnt_reg == CNT_CEIL) ? cnt_reg : cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      single_reg <= 1'b0;
      double_reg <= 1'b0;
      long_reg   <= 1'b0;
      busy_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      single_reg <= single_next;
      double_reg <= double_next;
      long_reg   <= long_next;
      busy_reg   <= busy_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    single_next = 1'b0;
    double_next = 1'b0;
    long_next   = 1'b0;

    case (state_reg)
      IDLE: begin
        if (rise) begin
          state_next = PRESS1;
          cnt_next   = '0;
        end
      end

      PRESS1: begin
        if (fall) begin
          state_next = WAIT_GAP;
          cnt_next   = '0;
        end else if (cnt_reg == LONG_LAST) begin
          state_next = HELD;
          long_next  = 1'b1;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      WAIT_GAP: begin
        // A rise on the timeout edge still counts as the second click.
        if (rise) begin
          state_next = PRESS2;
          cnt_next   = '0;
        end else if (cnt_reg == GAP_LAST) begin
          state_next  = IDLE;
          single_next = 1'b1;
          cnt_next    = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end

      PRESS2: begin
        // No long detection here: a held second press is still a double.
        if (fall) begin
          state_next  = IDLE;
          double_next = 1'b1;
          cnt_next    = '0;
        end
      end

      HELD: begin
`ifdef BUTTON_AUTO_REPEAT_EN
        // Release takes priority over a repeat falling on the same edge.
        if (fall) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_W'(REPEAT_CYCLES - 1)) begin
          long_next = 1'b1;
          cnt_next  = '0;
        end else begin
          cnt_next = cnt_inc;
        end
`else
        cnt_next = '0;
        if (fall) begin
          state_next = IDLE;
        end
`endif
      end

      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  assign single_pulse = single_reg;
  assign double_pulse = double_reg;
  assign long_pulse   = long_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_button_press_classifier.sv
// -----------------------------------------------------------------------------
// tb_button_press_classifier
// Self-checking bench: directed gesture scenarios with literal timing
// expectations plus randomized gestures, all compared every cycle against an
// elapsed-time reference model of the gesture rules.
// Build with +define+BUTTON_AUTO_REPEAT_EN to exercise the auto-repeat variant.
// -----------------------------------------------------------------------------
module tb_button_press_classifier;

  localparam int LONG = 8;
  localparam int GAP  = 6;
  localparam int REP  = 4;

  logic clk    = 1'b0;
  logic rst_n  = 1'b0;
  logic pb_deb = 1'b0;
  logic single_pulse, double_pulse, long_pulse, busy;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  button_press_classifier #(
    .LONG_CYCLES  (LONG),
    .GAP_CYCLES   (GAP),
    .REPEAT_CYCLES(REP),
    .CNT_W        (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pb_deb      (pb_deb),
    .single_pulse(single_pulse),
    .double_pulse(double_pulse),
    .long_pulse  (long_pulse),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------------------
  // Reference model: gesture phase plus the edge index at which the current
  // phase began; timeouts are elapsed-edge arithmetic.
  // phase 0 idle, 1 first press, 2 release gap, 3 second press, 4 long held
  // ---------------------------------------------------------------------------
  typedef struct packed {
    int   ph;
    int   t0;
    logic s;
    logic d;
    logic l;
  } step_t;

  function automatic step_t model_step(input int ph, input int t0, input int n,
                                       input logic r, input logic f);
    step_t o;
    o.ph = ph; o.t0 = t0; o.s = 1'b0; o.d = 1'b0; o.l = 1'b0;
    case (ph)
      0: if (r) begin o.ph = 1; o.t0 = n; end
      1: begin
        if (f) begin o.ph = 2; o.t0 = n; end
        else if (n - t0 == LONG) begin o.l = 1'b1; o.ph = 4; o.t0 = n; end
      end
      2: begin
        if (r) o.ph = 3;
        else if (n - t0 == GAP) begin o.s = 1'b1; o.ph = 0; end
      end
      3: if (f) begin o.d = 1'b1; o.ph = 0; end
      default: begin
        if (f) o.ph = 0;
`ifdef BUTTON_AUTO_REPEAT_EN
        else if ((n - t0) % REP == 0) o.l = 1'b1;
`endif
      end
    endcase
    return o;
  endfunction

  int         m_phase = 0;
  int         m_t0    = 0;
  int         m_n     = 0;
  logic       m_prev  = 1'b1;
  logic [3:0] exp_v   = 4'b0;   // {single, double, long, busy}
  step_t      m_st;

  always_comb m_st = model_step(m_phase, m_t0, m_n + 1,
                                pb_deb & ~m_prev, ~pb_deb & m_prev);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_prev  <= 1'b1;
      exp_v   <= 4'b0;
    end else begin
      m_phase <= m_st.ph;
      m_t0    <= m_st.t0;
      m_n     <= m_n + 1;
      m_prev  <= pb_deb;
      exp_v   <= {m_st.s, m_st.d, m_st.l, (m_st.ph != 0)};
    end
  end

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
  endtask

  // Every-cycle comparison against the model, plus the at-most-one-pulse rule.
  always @(negedge clk) begin
    check("model_cmp", int'({single_pulse, double_pulse, long_pulse, busy}), int'(exp_v));
    check("one_pulse_max",
          int'(single_pulse) + int'(double_pulse) + int'(long_pulse) > 1, 0);
  end

  // Pulse statistics for the directed scenarios.
  int s_cnt, d_cnt, l_cnt, s_first, d_first, l_first;

  task automatic clear_stats();
    s_cnt = 0; d_cnt = 0; l_cnt = 0;
    s_first = -1; d_first = -1; l_first = -1;
  endtask

  task automatic monitor_tick();
    if (single_pulse) begin if (s_first < 0) s_first = cyc; s_cnt++; end
    if (double_pulse) begin if (d_first < 0) d_first = cyc; d_cnt++; end
    if (long_pulse)   begin if (l_first < 0) l_first = cyc; l_cnt++; end
  endtask

  always @(negedge clk) monitor_tick();

  // Drive pb_deb at lvl for n sampling edges; returns 1 time unit after an edge.
  task automatic hold(input logic lvl, input int n);
    pb_deb = lvl;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int e;

  initial begin
    clear_stats();
    repeat (3) @(posedge clk);
    #1;
    check("reset_single", int'(single_pulse), 0);
    check("reset_double", int'(double_pulse), 0);
    check("reset_long",   int'(long_pulse), 0);
    check("reset_busy",   int'(busy), 0);
    rst_n = 1'b1;
    hold(1'b0, 3);

    // Single click: high 3, low 10 -> single 6 edges after the fall edge.
    clear_stats(); e = cyc + 1;
    hold(1'b1, 3); hold(1'b0, 10);
    check("single_time", s_first - e, 9);
    check("single_cnt", s_cnt, 1);
    check("single_no_other", d_cnt + l_cnt, 0);
    check("single_busy_after", int'(busy), 0);
    $display("txn single_click: single=%0d double=%0d long=%0d", s_cnt, d_cnt, l_cnt);

    // Double click: high 3, low 2, high 3, low -> double on second fall edge.
    clear_stats(); e = cyc + 1;
    hold(1'b1, 3); hold(1'b0, 2); hold(1'b1, 3); hold(1'b0, 10);
    check("double_time", d_first - e, 8);
    check("double_cnt", d_cnt, 1);
    check("double_no_single", s_cnt, 0);
    $display("txn double_click: single=%0d double=%0d long=%0d", s_cnt, d_cnt, l_cnt);

    // Long press: high 20 -> long 8 edges after the rise edge.
    clear_stats(); e = cyc + 1;
    hold(1'b1, 20); hold(1'b0, 10);
    check("long_time", l_first - e, 8);
`ifdef BUTTON_AUTO_REPEAT_EN
    check("long_cnt", l_cnt, 3);
`else
    check("long_cnt", l_cnt, 1);
`endif
    check("long_no_click", s_cnt + d_cnt, 0);
    $display("txn long_press: single=%0d double=%0d long=%0d", s_cnt, d_cnt, l_cnt);

    // Gap boundary: second rise on the timeout edge -> double.
    clear_stats(); e = cyc + 1;
    hold(1'b1, 3); hold(1'b0, 6); hold(1'b1, 2); hold(1'b0, 10);
    check("gap_edge_double", d_cnt, 1);
    check("gap_edge_single", s_cnt, 0);
    check("gap_edge_time", d_first - e, 11);
    $display("txn gap_boundary_rise: single=%0d double=%0d", s_cnt, d_cnt);

    // Rise one edge later -> single, then a new gesture (another single).
    clear_stats(); e = cyc + 1;
    hold(1'b1, 3); hold(1'b0, 7); hold(1'b1, 2); hold(1'b0, 10);
    check("gap_late_first", s_first - e, 9);
    check("gap_late_singles", s_cnt, 2);
    check("gap_late_double", d_cnt, 0);
    $display("txn gap_late_rise: single=%0d double=%0d", s_cnt, d_cnt);

    // Reset released with the button held: ignored until released and repressed.
    rst_n = 1'b0; hold(1'b1, 2); rst_n = 1'b1;
    clear_stats();
    hold(1'b1, 12);
    check("held_reset_busy", int'(busy), 0);
    check("held_reset_pulses", s_cnt + d_cnt + l_cnt, 0);
    hold(1'b0, 2);
    clear_stats(); e = cyc + 1;
    hold(1'b1, 3); hold(1'b0, 10);
    check("held_reset_then_single", s_first - e, 9);
    $display("txn reset_held_button: single=%0d", s_cnt);

    // Reset pulse in PRESS1 aborts the gesture.
    clear_stats();
    hold(1'b1, 3);
    check("press1_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("press1_reset_busy", int'(busy), 0);
    check("press1_reset_outs", int'({single_pulse, double_pulse, long_pulse}), 0);
    hold(1'b1, 2); rst_n = 1'b1;
    hold(1'b1, 12); hold(1'b0, 10);
    check("press1_reset_no_pulse", s_cnt + d_cnt + l_cnt, 0);
    $display("txn reset_in_press1: pulses=%0d", s_cnt + d_cnt + l_cnt);

    // Held second press: still a double on release, never a long.
    clear_stats(); e = cyc + 1;
    hold(1'b1, 3); hold(1'b0, 2); hold(1'b1, 15); hold(1'b0, 10);
    check("held2_long", l_cnt, 0);
    check("held2_double_time", d_first - e, 20);
    $display("txn held_second_press: double=%0d long=%0d", d_cnt, l_cnt);

    // Randomized gestures, checked every cycle against the model.
    for (int i = 0; i < 80; i++) begin
      int hi, lo;
      hi = int'($urandom_range(1, 25));
      lo = int'($urandom_range(1, 12));
      if ($urandom_range(0, 14) == 0) begin
        rst_n = 1'b0;
        hold(1'($urandom_range(0, 1)), 2);
        rst_n = 1'b1;
      end
      hold(1'b1, hi);
      hold(1'b0, lo);
      $display("txn random %0d: high=%0d low=%0d", i, hi, lo);
    end
    hold(1'b0, 15);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
